// File: rtl/divsr_if.sv
// Handshake and operand/result bundle between the ALU issue logic and divsr.
// The is_signed mode select exists only when DIVSR_SIGNED_EN is defined.
interface divsr_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef DIVSR_SIGNED_EN
  logic             is_signed;
`endif
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
`ifdef DIVSR_SIGNED_EN
    output is_signed,
`endif
    output start, a, b,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
`ifdef DIVSR_SIGNED_EN
    input  is_signed,
`endif
    input  start, a, b,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/divsr.sv
// divsr: sequential restoring shift-subtract divider, one quotient bit per clock.
// Define DIVSR_SIGNED_EN to add a signed (truncate toward zero) mode via is_signed.
module divsr #(
  parameter int unsigned WIDTH = 64
) (
  input  logic    clk,
  input  logic    rst,
  divsr_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;      // dividend in, quotient bits shift in from the LSB
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   r_pr;
  logic             r_dz_pend;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_b_zero;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_sub;
  logic             w_borrow;
  logic [WIDTH:0]   w_pr_nx;
  logic [WIDTH-1:0] w_q_nx;
  logic [WIDTH-1:0] w_q_out;
  logic [WIDTH-1:0] w_r_out;

  assign w_b_zero = (bus.b == '0);

  // One restoring step: shift in the next dividend bit, subtract, restore on borrow
  assign w_shift  = {r_pr, r_dvd[WIDTH-1]};
  assign w_sub    = w_shift - {2'b00, r_dvs};
  assign w_borrow = w_sub[WIDTH+1];
  assign w_pr_nx  = w_borrow ? w_shift[WIDTH:0] : w_sub[WIDTH:0];
  assign w_q_nx   = {r_dvd[WIDTH-2:0], ~w_borrow};

`ifdef DIVSR_SIGNED_EN
  logic w_a_neg;
  logic w_b_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_a_neg = bus.is_signed & bus.a[WIDTH-1];
  assign w_b_neg = bus.is_signed & bus.b[WIDTH-1];
  assign w_a_mag = w_a_neg ? WIDTH'(~bus.a + 1'b1) : bus.a;
  assign w_b_mag = w_b_neg ? WIDTH'(~bus.b + 1'b1) : bus.b;
  assign w_q_out = r_neg_q ? WIDTH'(~w_q_nx + 1'b1) : w_q_nx;
  assign w_r_out = r_neg_r ? WIDTH'(~w_pr_nx[WIDTH-1:0] + 1'b1) : w_pr_nx[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state != S_RUN && !r_dz_pend && bus.start) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end
`else
  assign w_a_mag = bus.a;
  assign w_b_mag = bus.b;
  assign w_q_out = w_q_nx;
  assign w_r_out = w_pr_nx[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_pr        <= '0;
      r_dz_pend   <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dz        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_RUN: begin
          r_pr  <= w_pr_nx;
          r_dvd <= w_q_nx;
          if (r_cnt == '0) begin
            r_state     <= S_FIN;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_quotient  <= w_q_out;
            r_remainder <= w_r_out;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          // Divide-by-zero spends one FIN cycle before publishing; start is not taken then
          if (r_dz_pend) begin
            r_dz_pend   <= 1'b0;
            r_state     <= S_FIN;
            r_quotient  <= '1;
            r_remainder <= r_dvd;
            r_dz        <= 1'b1;
            r_done      <= 1'b1;
          end else if (bus.start) begin
            r_dvd <= w_b_zero ? bus.a : w_a_mag;
            r_dvs <= w_b_mag;
            r_pr  <= '0;
            r_cnt <= CNT_W'(WIDTH - 1);
            r_dz  <= 1'b0;
            if (w_b_zero) begin
              r_state   <= S_FIN;
              r_dz_pend <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dz;

endmodule

// File: tb/tb_divsr.sv
// Directed self-checking bench for divsr (WIDTH=64); signed cases run when
// DIVSR_SIGNED_EN is defined.
module tb_divsr;

  localparam int unsigned WIDTH   = 64;
  localparam int          TIMEOUT = 300;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  divsr_if #(.WIDTH(WIDTH)) bus ();

  divsr #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start and wait (bounded) for done; cyc = edges after the accepting edge.
  task automatic do_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, output int cyc);
    bus.a     = ia;
    bus.b     = ib;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < TIMEOUT) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.quotient !== '0 || bus.remainder !== '0 || bus.busy !== 1'b0 ||
          bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: q=%h r=%h busy=%b done=%b dz=%b, want all zero",
                 i, bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
      end
    end
  endtask

  task automatic test_basic();
    int cyc;
    int busy_cnt;
    int held_bad;
    bus.a     = 64'd100;
    bus.b     = 64'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a     = 64'hFFFF;
    bus.b     = 64'd1;
    cyc = 0;
    busy_cnt = 0;
    held_bad = 0;
    while (bus.done !== 1'b1 && cyc < TIMEOUT) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.quotient !== '0 || bus.remainder !== '0) held_bad++;
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 64) begin errors++; $display("FAIL basic_latency: got %0d want 64", cyc); end
    checks++;
    if (busy_cnt !== 64) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 64", busy_cnt); end
    checks++;
    if (held_bad !== 0) begin errors++; $display("FAIL basic_no_update_in_run: %0d cycles changed, want 0", held_bad); end
    checks++;
    if (bus.quotient !== 64'd14 || bus.remainder !== 64'd2 || bus.div_by_zero !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: q=%0d r=%0d dz=%b busy=%b, want q=14 r=2 dz=0 busy=0",
               bus.quotient, bus.remainder, bus.div_by_zero, bus.busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.quotient !== 64'd14 || bus.remainder !== 64'd2) begin
        errors++;
        $display("FAIL basic_hold[%0d]: done=%b q=%0d r=%0d, want done=0 q=14 r=2",
                 i, bus.done, bus.quotient, bus.remainder);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int cyc;
    do_op(64'd5, 64'd0, cyc);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL dz_latency: got %0d want 1", cyc); end
    checks++;
    if (bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFF || bus.remainder !== 64'd5 || bus.div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dz_result: q=%h r=%0d dz=%b, want q=ffffffffffffffff r=5 dz=1",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b1 || bus.remainder !== 64'd5) begin
      errors++;
      $display("FAIL dz_hold: done=%b dz=%b r=%0d, want done=0 dz=1 r=5", bus.done, bus.div_by_zero, bus.remainder);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, cyc);
    checks++;
    if (cyc !== 64 || bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFF || bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: cyc=%0d q=%h r=%h dz=%b, want cyc=64 q=ffffffffffffffff r=0 dz=0",
               cyc, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    // start issued inside the done cycle
    bus.a     = 64'd3;
    bus.b     = 64'd10;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b q=%h, want busy=1 done=0 q=ffffffffffffffff",
               bus.busy, bus.done, bus.quotient);
    end
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < TIMEOUT) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 64 || bus.quotient !== '0 || bus.remainder !== 64'd3) begin
      errors++;
      $display("FAIL b2b_second: cyc=%0d q=%0d r=%0d, want cyc=64 q=0 r=3", cyc, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_start_while_busy();
    int cyc;
    bus.a     = 64'd50;
    bus.b     = 64'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < TIMEOUT) begin
      if (cyc == 9) begin
        bus.a     = 64'd9;
        bus.b     = 64'd3;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    checks++;
    if (cyc !== 64 || bus.quotient !== 64'd10 || bus.remainder !== '0) begin
      errors++;
      $display("FAIL busy_start_ignored: cyc=%0d q=%0d r=%0d, want cyc=64 q=10 r=0", cyc, bus.quotient, bus.remainder);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int saw_done;
    saw_done = 0;
    bus.a     = 64'd50;
    bus.b     = 64'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 30; i++) begin
      bus.start = (i == 10);
      if (i == 10) begin
        bus.a = 64'd9;
        bus.b = 64'd3;
      end
      tick();
      if (bus.done === 1'b1) saw_done++;
    end
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before_rst: busy=%b want 1", bus.busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.quotient !== '0 || bus.remainder !== '0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset_state: q=%h r=%h busy=%b done=%b dz=%b, want all zero",
               bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
    end
    for (int i = 0; i < 70; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done++;
    end
    checks++;
    if (saw_done !== 0) begin errors++; $display("FAIL abort_no_done: %0d done/busy cycles, want 0", saw_done); end
  endtask

  task automatic test_edges();
    logic [WIDTH-1:0] ta [8];
    logic [WIDTH-1:0] tb [8];
    logic [WIDTH-1:0] tq [8];
    logic [WIDTH-1:0] tr [8];
    int cyc;
    ta = '{64'd1000, 64'd123456789, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd3, 64'h8000_0000_0000_0000};
    tb = '{64'd33, 64'd123456789, 64'h1_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd2, 64'd5, 64'd10, 64'd3};
    tq = '{64'd30, 64'd1, 64'h0000_DEAD_BEEF_0123, 64'd1,
           64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'h2AAA_AAAA_AAAA_AAAA};
    tr = '{64'd10, 64'd0, 64'h4567, 64'd0, 64'd1, 64'd0, 64'd3, 64'd2};
    for (int i = 0; i < 8; i++) begin
      do_op(ta[i], tb[i], cyc);
      checks++;
      if (cyc !== 64 || bus.quotient !== tq[i] || bus.remainder !== tr[i]) begin
        errors++;
        $display("FAIL edge[%0d]: cyc=%0d q=%h r=%h, want cyc=64 q=%h r=%h",
                 i, cyc, bus.quotient, bus.remainder, tq[i], tr[i]);
      end
    end
  endtask

`ifdef DIVSR_SIGNED_EN
  task automatic test_signed();
    logic [WIDTH-1:0] ta [6];
    logic [WIDTH-1:0] tb [6];
    logic [WIDTH-1:0] tq [6];
    logic [WIDTH-1:0] tr [6];
    logic             ts [6];
    logic             tz [6];
    int cyc;
    ta = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd7, 64'hFFFF_FFFF_FFFF_FFF9,
           64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF9};
    tb = '{64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE,
           64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd2};
    tq = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD, 64'd3,
           64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFC};
    tr = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd1};
    ts = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      bus.is_signed = ts[i];
      do_op(ta[i], tb[i], cyc);
      bus.is_signed = 1'b0;
      checks++;
      if (cyc !== (tz[i] ? 1 : 64) || bus.quotient !== tq[i] || bus.remainder !== tr[i] ||
          bus.div_by_zero !== tz[i]) begin
        errors++;
        $display("FAIL signed[%0d]: cyc=%0d q=%h r=%h dz=%b, want cyc=%0d q=%h r=%h dz=%b",
                 i, cyc, bus.quotient, bus.remainder, bus.div_by_zero,
                 tz[i] ? 1 : 64, tq[i], tr[i], tz[i]);
      end
    end
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef DIVSR_SIGNED_EN
    bus.is_signed = 1'b0;
`endif
    test_reset();
    test_basic();
    test_div_by_zero();
    test_back_to_back();
    test_start_while_busy();
    test_reset_abort();
    test_edges();
`ifdef DIVSR_SIGNED_EN
    test_signed();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
